// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: load funct3 codes, x0 index,
// and the pending-load FIFO entry layout.
package wb_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } pend_entry_t;
endpackage

// File: rtl/extensor_carga.sv
// Load data extractor: picks the byte/halfword at the address offset and
// sign- or zero-extends it; unknown funct3 codes pass the full word through.
module extensor_carga
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_addr_lo,
  output logic [DATA_W-1:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
      F3_LW:   o_data = i_word;
      default: o_data = i_word;
    endcase
  end
endmodule

// File: rtl/etapa_writeback.sv
// Write-back stage: arbitrates load responses, a one-entry ALU skid and the
// direct ALU path onto the register-file write port, tracks outstanding loads
// in a FIFO and a busy scoreboard for decode hazards.
// Optional macro WB_FORWARD_EN adds write-port forwarding to rs1/rs2.
module etapa_writeback
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              ld_issue,
  input  logic [4:0]        ld_rd,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  input  logic              ld_resp_valid,
  input  logic [DATA_W-1:0] ld_resp_data,
  output logic              pend_full,
  output logic              ovf_err,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              stall,
`ifdef WB_FORWARD_EN
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data,
`endif
  output logic [4:0]        writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              RegWrite
);
  localparam int PW = $clog2(MAX_PEND);

  pend_entry_t       r_fifo [MAX_PEND];
  logic [PW:0]       r_wptr, r_rptr;
  logic              r_skid_vld;
  logic [4:0]        r_skid_rd;
  logic [DATA_W-1:0] r_skid_data;
  logic [31:0]       r_busy;
  logic              r_ovf;
  logic              r_we;
  logic [4:0]        r_wr;
  logic [DATA_W-1:0] r_wd;

  logic              w_empty, w_full, w_pop, w_push, w_alu_acc;
  pend_entry_t       w_head, w_push_ent;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_wr_any;
  logic [4:0]        w_rd_sel;
  logic [DATA_W-1:0] w_data_sel;
  logic [31:0]       w_busy_nxt;
  logic              w_hz1, w_hz2, w_f1, w_f2;

  // Extra pointer bit distinguishes full from empty.
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PW-1:0] == r_rptr[PW-1:0]) && (r_wptr[PW] != r_rptr[PW]);
  assign w_pop      = ld_resp_valid && !w_empty;
  assign w_push     = ld_issue && (!w_full || w_pop);
  assign w_head     = r_fifo[r_rptr[PW-1:0]];
  assign w_push_ent = '{rd: ld_rd, funct3: ld_funct3, addr_lo: ld_addr_lo};
  assign w_alu_acc  = alu_valid && !r_skid_vld;

  extensor_carga #(.DATA_W(DATA_W)) u_ext (
    .i_word    (ld_resp_data),
    .i_funct3  (w_head.funct3),
    .i_addr_lo (w_head.addr_lo),
    .o_data    (w_ld_data)
  );

  always_comb begin
    w_wr_any   = 1'b0;
    w_rd_sel   = REG_ZERO;
    w_data_sel = '0;
    if (w_pop) begin
      w_wr_any   = 1'b1;
      w_rd_sel   = w_head.rd;
      w_data_sel = w_ld_data;
    end else if (r_skid_vld) begin
      w_wr_any   = 1'b1;
      w_rd_sel   = r_skid_rd;
      w_data_sel = r_skid_data;
    end else if (w_alu_acc) begin
      w_wr_any   = 1'b1;
      w_rd_sel   = alu_rd;
      w_data_sel = alu_result;
    end
  end

  // Clear on the committing write first so a same-cycle issue re-sets the bit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) w_busy_nxt[r_wr] = 1'b0;
    if (w_push && (ld_rd != REG_ZERO)) w_busy_nxt[ld_rd] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_fifo[r_wptr[PW-1:0]] <= w_push_ent;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_rd   <= REG_ZERO;
      r_skid_data <= '0;
      r_busy      <= '0;
      r_ovf       <= 1'b0;
      r_we        <= 1'b0;
      r_wr        <= REG_ZERO;
      r_wd        <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if ((ld_issue && !w_push) || (ld_resp_valid && w_empty)) r_ovf <= 1'b1;
      if (w_pop && w_alu_acc) begin
        r_skid_vld  <= 1'b1;
        r_skid_rd   <= alu_rd;
        r_skid_data <= alu_result;
      end else if (!w_pop && r_skid_vld) begin
        r_skid_vld  <= 1'b0;
      end
      r_busy <= w_busy_nxt;
      r_we   <= w_wr_any && (w_rd_sel != REG_ZERO);
      if (w_wr_any) begin
        r_wr <= w_rd_sel;
        r_wd <= w_data_sel;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign w_f1      = r_we && (r_wr == rs1) && (rs1 != REG_ZERO);
  assign w_f2      = r_we && (r_wr == rs2) && (rs2 != REG_ZERO);
  assign fwd1_hit  = w_f1;
  assign fwd2_hit  = w_f2;
  assign fwd1_data = r_wd;
  assign fwd2_data = r_wd;
`else
  assign w_f1 = 1'b0;
  assign w_f2 = 1'b0;
`endif

  assign w_hz1     = (rs1 != REG_ZERO) && r_busy[rs1];
  assign w_hz2     = (rs2 != REG_ZERO) && r_busy[rs2];
  assign stall     = (w_hz1 && !w_f1) || (w_hz2 && !w_f2);
  assign alu_ready = !r_skid_vld;
  assign pend_full = w_full;
  assign ovf_err   = r_ovf;
  assign RegWrite  = r_we;
  assign writeReg  = r_wr;
  assign writeData = r_wd;
endmodule

// File: tb/tb_etapa_writeback.sv
// Bench for etapa_writeback: queue-based behavioural model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_etapa_writeback;
  localparam int DATA_W   = 32;
  localparam int MAX_PEND = 2;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        alu_valid, ld_issue, ld_resp_valid;
  logic [4:0]  alu_rd, ld_rd, rs1, rs2;
  logic [31:0] alu_result, ld_resp_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        alu_ready, pend_full, ovf_err, stall, RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  etapa_writeback #(.DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .pend_full(pend_full), .ovf_err(ovf_err), .rs1(rs1), .rs2(rs2), .stall(stall),
    .writeReg(writeReg), .writeData(writeData), .RegWrite(RegWrite)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference load semantics written from the ISA meaning of each funct3.
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (a[1] ? (w >> 16) : w) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
      3'b100:  return b;
      3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  typedef struct { logic [4:0] rd; logic [2:0] f3; logic [1:0] a; } ld_t;
  ld_t         pq[$];
  logic [4:0]  sk_rd[$];
  logic [31:0] sk_d[$];
  bit [31:0]   m_busy;
  bit          m_we, m_ovf;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  always @(posedge CLK or negedge RESET_N) begin
    bit          resp, alu_ok, wrote, can_push;
    logic [4:0]  rd;
    logic [31:0] d;
    bit [31:0]   nb;
    if (!RESET_N) begin
      pq.delete(); sk_rd.delete(); sk_d.delete();
      m_busy = '0; m_we = 0; m_ovf = 0; m_wr = '0; m_wd = '0;
    end else begin
      resp     = ld_resp_valid && (pq.size() > 0);
      alu_ok   = alu_valid && (sk_rd.size() == 0);
      can_push = (pq.size() < MAX_PEND) || resp;
      nb = m_busy;
      if (m_we) nb[m_wr] = 1'b0;
      wrote = 0; rd = '0; d = '0;
      if (resp) begin
        rd = pq[0].rd; d = ext(ld_resp_data, pq[0].f3, pq[0].a); wrote = 1;
        if (alu_ok) begin sk_rd.push_back(alu_rd); sk_d.push_back(alu_result); end
        void'(pq.pop_front());
      end else if (sk_rd.size() > 0) begin
        rd = sk_rd.pop_front(); d = sk_d.pop_front(); wrote = 1;
      end else if (alu_ok) begin
        rd = alu_rd; d = alu_result; wrote = 1;
      end
      if (ld_resp_valid && !resp) m_ovf = 1;
      if (ld_issue) begin
        if (can_push) begin
          pq.push_back('{rd: ld_rd, f3: ld_funct3, a: ld_addr_lo});
          if (ld_rd != 0) nb[ld_rd] = 1'b1;
        end else m_ovf = 1;
      end
      m_we = wrote && (rd != 0);
      if (wrote) begin m_wr = rd; m_wd = d; end
      m_busy = nb;
    end
  end

  always @(negedge CLK) begin
    if (RESET_N) begin
      chk("RegWrite", RegWrite, m_we);
      if (m_we) begin
        chk("writeReg", writeReg, m_wr);
        chk("writeData", writeData, m_wd);
      end
      chk("alu_ready", alu_ready, sk_rd.size() == 0);
      chk("pend_full", pend_full, pq.size() == MAX_PEND);
      chk("ovf_err", ovf_err, m_ovf);
      chk("stall", stall, ((rs1 != 0) && m_busy[rs1]) || ((rs2 != 0) && m_busy[rs2]));
    end
  end

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_issue = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
    ld_resp_valid = 0; ld_resp_data = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic step();
    @(posedge CLK); #2;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a);
    ld_issue = 1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = a;
  endtask

  task automatic resp(input logic [31:0] d);
    ld_resp_valid = 1; ld_resp_data = d;
  endtask

  initial begin
    idle();
    RESET_N = 0;
    #12;
    chk("rst RegWrite", RegWrite, 0);
    chk("rst writeReg", writeReg, 0);
    chk("rst writeData", writeData, 0);
    chk("rst ovf", ovf_err, 0);
    chk("rst pend_full", pend_full, 0);
    chk("rst alu_ready", alu_ready, 1);
    chk("rst stall", stall, 0);
    @(posedge CLK); #2; RESET_N = 1;

    // ALU write
    alu_valid = 1; alu_rd = 5; alu_result = 32'h0000A234;
    step(); idle(); #1;
    chk("alu we", RegWrite, 1);
    chk("alu rd", writeReg, 5);
    chk("alu data", writeData, 32'h0000A234);
    step(); #1;
    chk("alu we drop", RegWrite, 0);

    // LB / LBU
    issue(7, 3'b000, 2); step(); idle(); rs1 = 7; #1;
    chk("lb stall", stall, 1);
    resp(32'h12F45678); step(); idle(); rs1 = 7; #1;
    chk("lb rd", writeReg, 7);
    chk("lb data", writeData, 32'hFFFFFFF4);
    chk("lb stall commit", stall, 1);
    step(); #1;
    chk("lb stall clear", stall, 0);
    issue(8, 3'b100, 2); step(); idle();
    resp(32'h12F45678); step(); idle(); #1;
    chk("lbu data", writeData, 32'h000000F4);
    step();

    // Hazard with LW
    issue(9, 3'b010, 0); step(); idle(); rs1 = 9; #1;
    chk("hz stall", stall, 1);
    step(); step(); step(); #1;
    chk("hz stall hold", stall, 1);
    rs1 = 0; rs2 = 0; #1;
    chk("hz x0 no stall", stall, 0);
    rs1 = 9; resp(32'hDEADBEEF); step(); ld_resp_valid = 0; #1;
    chk("hz data", writeData, 32'hDEADBEEF);
    chk("hz still busy", stall, 1);
    step(); #1;
    chk("hz released", stall, 0);
    idle();

    // Collision: load response beats ALU, ALU parks in skid
    issue(3, 3'b010, 0); step(); idle();
    resp(32'h11111111); alu_valid = 1; alu_rd = 4; alu_result = 32'h44;
    step(); idle(); #1;
    chk("col rd3", writeReg, 3);
    chk("col data3", writeData, 32'h11111111);
    chk("col alu_ready", alu_ready, 0);
    step(); #1;
    chk("col rd4", writeReg, 4);
    chk("col data4", writeData, 32'h44);
    chk("col ready back", alu_ready, 1);

    // x0 and illegal funct3
    alu_valid = 1; alu_rd = 0; alu_result = 32'hFFFF; step(); idle(); #1;
    chk("x0 no write", RegWrite, 0);
    issue(6, 3'b011, 1); step(); idle();
    resp(32'hCAFEBABE); step(); idle(); #1;
    chk("illegal f3 as lw", writeData, 32'hCAFEBABE);

    // Full FIFO: simultaneous push/pop, then overflow
    issue(10, 3'b001, 2); step();
    issue(11, 3'b101, 0); step(); idle(); #1;
    chk("full", pend_full, 1);
    issue(15, 3'b010, 0); resp(32'h80011234); step(); idle(); #1;
    chk("pushpop full", pend_full, 1);
    chk("pushpop no ovf", ovf_err, 0);
    chk("lh data", writeData, 32'hFFFF8001);
    issue(12, 3'b010, 0); step(); idle(); rs1 = 12; #1;
    chk("ovf set", ovf_err, 1);
    chk("dropped not busy", stall, 0);
    resp(32'h00009ABC); step(); idle(); #1;
    chk("lhu data", writeData, 32'h00009ABC);
    resp(32'h55667788); step(); idle(); #1;
    chk("lw15 rd", writeReg, 15);
    resp(32'h1); step(); idle(); #1;
    chk("ovf sticky", ovf_err, 1);
    step();

    // Reset with two loads pending and a write on the port
    RESET_N = 0; #3; RESET_N = 1; step();
    issue(13, 3'b010, 0); step();
    issue(14, 3'b010, 0); step(); idle();
    alu_valid = 1; alu_rd = 20; alu_result = 32'h1; step(); idle(); rs1 = 13; #1;
    chk("pre-rst full", pend_full, 1);
    chk("pre-rst we", RegWrite, 1);
    RESET_N = 0; #1;
    chk("mid-rst pend_full", pend_full, 0);
    chk("mid-rst RegWrite", RegWrite, 0);
    chk("mid-rst stall", stall, 0);
    chk("mid-rst ovf", ovf_err, 0);
    chk("mid-rst alu_ready", alu_ready, 1);
    step(); RESET_N = 1;
    resp(32'h2); step(); idle(); #1;
    chk("post-rst empty resp ovf", ovf_err, 1);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/etapa_writeback.md
Name: etapa_writeback

Overview:
- Write-back stage of the pipelined core.
- It is the sole driver of the banco_registros write port (writeReg, writeData, RegWrite).
- It merges ALU results and in-order load responses from data memory, and sign- or zero-extends load data.
- It keeps a busy scoreboard of registers with outstanding loads, so decode can stall on read-after-write hazards.

Parameters:
- DATA_W, 32, register and data width.
- MAX_PEND, 2, maximum number of outstanding loads (pending FIFO depth, power of 2).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered this cycle.
- alu_ready  out  1  ALU result accepted; high when the skid register is empty.
- alu_rd  in  5  ALU destination register.
- alu_result  in  DATA_W  ALU result.
- ld_issue  in  1  load issued to data memory this cycle.
- ld_rd  in  5  load destination register.
- ld_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- ld_addr_lo  in  2  byte offset of the load address.
- ld_resp_valid  in  1  memory returns a word (responses arrive in order).
- ld_resp_data  in  DATA_W  aligned memory word.
- pend_full  out  1  pending FIFO full; the issuer must not assert ld_issue.
- ovf_err  out  1  sticky flag: issue while full, or response while empty.
- rs1, rs2  in  5  decode source registers.
- stall  out  1  hazard stall request to decode.
- writeReg  out  5  to banco_registros.writeReg.
- writeData  out  DATA_W  to banco_registros.writeData.
- RegWrite  out  1  to banco_registros.RegWrite.

Behaviour:
- Reset (async, RESET_N=0):
  - writeReg=0, writeData=0, RegWrite=0, ovf_err=0.
  - Scoreboard busy[31:0]=0; FIFO and skid register empty, so pend_full=0 and alu_ready=1.
  - Reset mid-operation discards all pending loads and any skid contents.
- Outputs writeReg, writeData and RegWrite are registered. Latency is one edge from an accepted event to RegWrite=1; banco_registros commits on the following edge.
- Write arbitration (one write per cycle), in priority order:
  - 1) Load response.
  - 2) Skid register.
  - 3) Direct ALU input.
  - An ALU result that loses arbitration while alu_ready=1 is captured in the skid register.
  - alu_ready=0 while the skid register is occupied. The skid register drains on the first cycle with no load response.
- ld_issue with FIFO not full: push {rd, funct3, addr_lo}; set busy[rd] unless rd=0.
- ld_issue while full: dropped, ovf_err set.
- ld_resp_valid with FIFO empty: ignored, ovf_err set.
- ld_resp_valid with FIFO not empty: pop the head entry; extract the byte or halfword at addr_lo (halfword uses addr_lo[1]); extend per funct3.
- Illegal funct3: treated as LW.
- rd=0: never produces RegWrite=1. The load still pops its FIFO entry; an ALU result to rd=0 is accepted and discarded.
- busy[r] clears at the edge where RegWrite=1 and writeReg=r. If an issue to the same register occurs in that cycle, set wins.
- Simultaneous push and pop when full: legal; occupancy is unchanged.
- stall = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]); combinational.
- WAW: an ALU write to a busy register is performed. The later load response overwrites it (program order).

Optional Feature:
- Macro WB_FORWARD_EN.
- When defined:
  - Adds outputs fwd1_hit, fwd2_hit (1 bit) and fwd1_data, fwd2_data (DATA_W).
  - fwdN_hit=1 when RegWrite=1, writeReg=rsN and rsN!=0; fwdN_data=writeData.
  - stall ignores a busy register whose value is being forwarded this cycle.
- When undefined: no extra ports; stall exactly as above.

Decomposition:
- Package wb_pkg:
  - load funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - REG_ZERO;
  - packed struct pend_entry_t {rd, funct3, addr_lo}.
- Sub-module extensor_carga: combinational byte/halfword select and sign/zero extension, taking (word, funct3, addr_lo) and returning DATA_W.
- The FIFO, scoreboard and arbitration stay in etapa_writeback.

Test Plan:
- ALU write: alu_valid=1, rd=5, result=0x0000A234 -> next edge RegWrite=1, writeReg=5, writeData=0x0000A234; banco_registros reads 0xA234 afterwards.
- Load extension: issue LB rd=7 addr_lo=2, response 0x12F45678 -> writeData=0xFFFFFFF4. With LBU the same response gives 0x000000F4.
- Hazard: issue LW rd=9, rs1=9 -> stall=1 until the edge committing rd=9. rs1=0 with busy never stalls.
- Collision: load response rd=3 and alu_valid rd=4 in the same cycle -> rd=3 written first, alu_ready=0 for one cycle, rd=4 written the next cycle.
- x0 and overflow: ALU write to rd=0 -> RegWrite stays 0. Three issues with MAX_PEND=2 -> pend_full=1, third issue dropped, ovf_err=1.
- Reset mid-load: RESET_N low with 2 pending -> busy=0, pend_full=0, RegWrite=0 immediately.
